timer_unit: RTL and testbench

TIMER_UNIT -- requirements
Module: timer_unit

---
 rtl/timer_unit_pkg.sv | 30 +++
 rtl/timer_prescaler.sv | 26 ++
 rtl/timer_unit.sv | 137 +++++++++++++
 tb/tb_timer_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_unit_pkg.sv
// Shared constants for the timer: register map, CTRL bit layout, mode codes and FSM states.
package timer_unit_pkg;

  localparam logic [31:0] TIMER_ADDR_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER_ADDR_LAST = 32'h0000_7F0F;

  // Word index within the timer window, taken from address bits [3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PSC_LSB  = 8;
  localparam int CTRL_PSC_MSB  = 15;

  localparam logic [1:0] MODE_ONE_SHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO     = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides enabled counting cycles by psc+1; tick marks the cycle on which COUNT may step.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] psc,
  output logic       tick
);

  logic [7:0] div_cnt;

  // Using >= keeps the divider sane if psc is lowered below the running count
  assign tick = enable && (div_cnt >= psc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and maskable IRQ.
// Optional prescaler in CTRL[15:8] is built only when TIMER_PRESCALER_EN is defined.
module timer_unit
  import timer_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] I_Addr,
  input  logic        I_WE,
  input  logic [31:0] I_WData,
  output logic [31:0] O_RData,
  output logic        O_IRQ
);

  timer_state_e state;
  logic         en;
  logic         im;
  logic [1:0]   mode;
  logic [31:0]  preset;
  logic [31:0]  count;
  logic         irq_flag;
  logic         tick;
  logic         wr_ctrl;
  logic         wr_preset;
  logic         auto_mode;

  assign wr_ctrl   = I_WE && (I_Addr[3:2] == REG_CTRL);
  assign wr_preset = I_WE && (I_Addr[3:2] == REG_PRESET);
  assign auto_mode = (mode == MODE_AUTO);

`ifdef TIMER_PRESCALER_EN
  logic [7:0] psc;
  logic       unused_bits;

  assign unused_bits = ^{I_Addr[31:4], I_Addr[1:0], I_WData[31:16], I_WData[7:4]};

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state == ST_IDLE) || (state == ST_LOAD)),
    .enable ((state == ST_CNT) && en),
    .psc    (psc),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc <= '0;
    end else if (wr_ctrl) begin
      psc <= I_WData[CTRL_PSC_MSB:CTRL_PSC_LSB];
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{I_Addr[31:4], I_Addr[1:0], I_WData[31:4]};
  assign tick        = 1'b1;
`endif

  // CPU writes to CTRL take precedence over the FSM clearing EN at the end of a one-shot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      im       <= 1'b0;
      mode     <= MODE_ONE_SHOT;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_preset) begin
        preset <= I_WData;
      end

      if (wr_ctrl) begin
        en   <= I_WData[CTRL_EN];
        mode <= I_WData[CTRL_MODE_MSB:CTRL_MODE_LSB];
        im   <= I_WData[CTRL_IM];
      end else if ((state == ST_INT) && !auto_mode) begin
        en <= 1'b0;
      end

      // Auto-reload drops the flag after one cycle; one-shot holds it until CTRL is rewritten
      if (state == ST_INT) begin
        irq_flag <= 1'b1;
      end else if (wr_ctrl || auto_mode) begin
        irq_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= '0;
              state <= ST_INT;
            end
          end
        end
        ST_INT: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    O_RData = '0;
    case (I_Addr[3:2])
      REG_CTRL: begin
        O_RData[CTRL_EN]                     = en;
        O_RData[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
        O_RData[CTRL_IM]                     = im;
`ifdef TIMER_PRESCALER_EN
        O_RData[CTRL_PSC_MSB:CTRL_PSC_LSB]   = psc;
`endif
      end
      REG_PRESET: O_RData = preset;
      REG_COUNT:  O_RData = count;
      default:    O_RData = '0;
    endcase
  end

  assign O_IRQ = irq_flag && im;

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit; define TIMER_PRESCALER_EN to also exercise the prescaler.
module tb_timer_unit;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

  logic        clk;
  logic        reset;
  logic [31:0] I_Addr;
  logic        I_WE;
  logic [31:0] I_WData;
  logic [31:0] O_RData;
  logic        O_IRQ;

  int vectors;
  int miscompares;

  timer_unit dut (
    .clk     (clk),
    .reset   (reset),
    .I_Addr  (I_Addr),
    .I_WE    (I_WE),
    .I_WData (I_WData),
    .O_RData (O_RData),
    .O_IRQ   (O_IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: k edges after the enabling write, with divider s = psc+1 and c0 = 0 at start
  function automatic int model_count(int p, int s, bit auto_md, int k);
    int pp, t, m, d;
    pp = (p < 1) ? 1 : p;
    t  = 2 + s * pp + 1;
    if (auto_md) m = ((k - 1) % t) + 1;
    else         m = (k > t) ? t : k;
    if (m < 2) return 0;
    d = (m - 2) / s;
    return (p - d > 0) ? (p - d) : 0;
  endfunction

  function automatic bit model_irq(int p, int s, bit auto_md, int k);
    int pp, t;
    pp = (p < 1) ? 1 : p;
    t  = 2 + s * pp + 1;
    if (auto_md) return (k % t) == 0;
    return k >= t;
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    I_Addr  = addr;
    I_WData = data;
    I_WE    = 1'b1;
    @(posedge clk);
    #1;
    I_WE    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    I_Addr = addr;
    #1;
    data = O_RData;
  endtask

  task automatic apply_reset();
    I_WE    = 1'b0;
    I_WData = '0;
    I_Addr  = A_CTRL;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] addrs [4];
    addrs[0] = A_CTRL; addrs[1] = A_PRESET; addrs[2] = A_COUNT; addrs[3] = A_RSVD;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], rd);
      vectors++;
      if (rd !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, rd, 32'h0);
      end
    end
    vectors++;
    if (O_IRQ !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_irq: got %b expected 0", O_IRQ);
    end
  endtask

  task automatic test_register_access();
    logic [31:0] rd, pv, cv, exp_ctrl;
    apply_reset();
    pv = $urandom;
    cv = $urandom & 32'hFFFF_FFFE;
`ifdef TIMER_PRESCALER_EN
    exp_ctrl = cv & 32'h0000_FF0E;
`else
    exp_ctrl = cv & 32'h0000_000E;
`endif
    bus_write(A_PRESET, pv);
    bus_write(A_CTRL, cv);
    bus_write(A_COUNT, 32'hDEAD_BEEF);
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    bus_read(A_PRESET, rd);
    vectors++;
    if (rd !== pv) begin
      miscompares++;
      $display("[TB] FAIL preset_rb: got %h expected %h", rd, pv);
    end
    bus_read(A_CTRL, rd);
    vectors++;
    if (rd !== exp_ctrl) begin
      miscompares++;
      $display("[TB] FAIL ctrl_rb: got %h expected %h", rd, exp_ctrl);
    end
    bus_read(A_COUNT, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL count_ro: got %h expected %h", rd, 32'h0);
    end
    bus_read(A_RSVD, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rsvd_rb: got %h expected %h", rd, 32'h0);
    end
  endtask

  // Runs cycles 1..ncyc after the enabling write, comparing COUNT and O_IRQ with the model
  task automatic run_and_check(input string tag, input int p, input int s, input bit auto_md,
                               input bit im, input int ncyc);
    logic [31:0] rd;
    int exp_c;
    bit exp_i;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      bus_read(A_COUNT, rd);
      exp_c = model_count(p, s, auto_md, k);
      exp_i = im && model_irq(p, s, auto_md, k);
      vectors++;
      if (rd !== 32'(exp_c)) begin
        miscompares++;
        $display("[TB] FAIL %s_count k=%0d: got %0d expected %0d", tag, k, rd, exp_c);
      end
      vectors++;
      if (O_IRQ !== exp_i) begin
        miscompares++;
        $display("[TB] FAIL %s_irq k=%0d: got %b expected %b", tag, k, O_IRQ, exp_i);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] rd;
    apply_reset();
    bus_write(A_PRESET, 32'd3);
    bus_write(A_CTRL, 32'h9);
    run_and_check("oneshot", 3, 1, 1'b0, 1'b1, 10);
    bus_read(A_CTRL, rd);
    vectors++;
    if (rd !== 32'h8) begin
      miscompares++;
      $display("[TB] FAIL oneshot_en_cleared: got %h expected %h", rd, 32'h8);
    end
    bus_write(A_CTRL, 32'h8);
    vectors++;
    if (O_IRQ !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oneshot_irq_clear: got %b expected 0", O_IRQ);
    end
  endtask

  task automatic test_auto_reload();
    apply_reset();
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'hB);
    run_and_check("auto", 2, 1, 1'b1, 1'b1, 21);
  endtask

  task automatic test_masking();
    logic [31:0] rd;
    apply_reset();
    bus_write(A_PRESET, 32'd1);
    bus_write(A_CTRL, 32'h1);
    run_and_check("mask", 1, 1, 1'b0, 1'b0, 8);
    bus_read(A_CTRL, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mask_en_cleared: got %h expected %h", rd, 32'h0);
    end
    bus_write(A_CTRL, 32'h8);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (O_IRQ !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mask_unmask_irq k=%0d: got %b expected 0", k, O_IRQ);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Disable write is issued while COUNT shows 7, so it lands as COUNT steps to 6
  task automatic test_disable_mid_count();
    logic [31:0] rd;
    bit found;
    apply_reset();
    bus_write(A_PRESET, 32'd10);
    bus_write(A_CTRL, 32'h9);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk);
      #1;
      bus_read(A_COUNT, rd);
      if (rd == 32'd7) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL disable_wait: got timeout expected COUNT=7");
    end
    bus_write(A_CTRL, 32'h8);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      bus_read(A_COUNT, rd);
      vectors++;
      if (rd !== 32'd6 || O_IRQ !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL disable_hold k=%0d: got count=%0d irq=%b expected count=6 irq=0",
                 k, rd, O_IRQ);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] rd;
    logic [31:0] addrs [3];
    bit found;
    addrs[0] = A_CTRL; addrs[1] = A_PRESET; addrs[2] = A_COUNT;
    apply_reset();
    bus_write(A_PRESET, 32'd10);
    bus_write(A_CTRL, 32'h9);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk);
      #1;
      bus_read(A_COUNT, rd);
      if (rd == 32'd4) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL rstmid_wait: got timeout expected COUNT=4");
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_read(addrs[i], rd);
      vectors++;
      if (rd !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_reg%0d: got %h expected %h", i, rd, 32'h0);
      end
    end
    vectors++;
    if (O_IRQ !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_irq: got %b expected 0", O_IRQ);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    bus_read(A_COUNT, rd);
    vectors++;
    if (rd !== 32'h0 || O_IRQ !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_stays_idle: got count=%0d irq=%b expected count=0 irq=0", rd, O_IRQ);
    end
  endtask

  task automatic test_random();
    int p, md;
    bit auto_md;
    for (int it = 0; it < 12; it++) begin
      p       = $urandom_range(0, 12);
      md      = $urandom_range(0, 3);
      auto_md = (md == 1);
      apply_reset();
      bus_write(A_PRESET, 32'(p));
      bus_write(A_CTRL, 32'h9 | 32'(md << 1));
      run_and_check($sformatf("rnd%0d_p%0d_m%0d", it, p, md), p, 1, auto_md, 1'b1,
                    2 * ((p < 1 ? 1 : p) + 3) + 2);
    end
  endtask

`ifdef TIMER_PRESCALER_EN
  task automatic test_prescaler();
    logic [31:0] rd;
    apply_reset();
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'h309);
    run_and_check("psc", 2, 4, 1'b0, 1'b1, 13);
    bus_read(A_CTRL, rd);
    vectors++;
    if (rd !== 32'h308) begin
      miscompares++;
      $display("[TB] FAIL psc_ctrl_rb: got %h expected %h", rd, 32'h308);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    I_WE        = 1'b0;
    I_Addr      = '0;
    I_WData     = '0;
    test_reset();
    test_register_access();
    test_one_shot();
    test_auto_reload();
    test_masking();
    test_disable_mid_count();
    test_reset_mid_count();
    test_random();
`ifdef TIMER_PRESCALER_EN
    test_prescaler();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
